// File: rtl/uart_rx_oversampled_if.sv
// rtl/uart_rx_oversampled_if.sv - serial line and receive-side outputs of the oversampled UART receiver
//
// Purpose: bundles the asynchronous rx line with the byte/strobe outputs.
// Signals:
//   rx           serial line, idle high, asynchronous to clk
//   rx_byte      last correctly framed byte
//   received     one-cycle strobe, rx_byte updated
//   recv_error   one-cycle strobe, stop bit sampled low
//   is_receiving high while a frame is in progress
// Modports: master drives the line and observes outputs; slave is the receiver.
`timescale 1ns/1ps
interface uart_rx_oversampled_if;
  logic       rx;
  logic [7:0] rx_byte;
  logic       received;
  logic       recv_error;
  logic       is_receiving;

  modport master (
    output rx,
    input  rx_byte, received, recv_error, is_receiving
  );

  modport slave (
    input  rx,
    output rx_byte, received, recv_error, is_receiving
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - 8N1 UART receiver with start-edge re-centring and 3-sample majority vote
//
// Purpose: recovers 8N1 bytes from an asynchronous line, flags framing errors.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  uart_rx_oversampled_if.slave (rx in; rx_byte, received, recv_error,
//        is_receiving out)
// Parameters: CLOCKFRQ (Hz), BAUDRATE (baud); CLOCKFRQ/BAUDRATE must be >= 4.
`timescale 1ns/1ps
module uart_rx_oversampled #(
  parameter int CLOCKFRQ = 12000000,
  parameter int BAUDRATE = 1000000
) (
  input logic                   clk,
  input logic                   rst,
  uart_rx_oversampled_if.slave  bus
);

  localparam int DIV = CLOCKFRQ / BAUDRATE;
  localparam int H   = DIV / 2;
  localparam int CW  = $clog2(10 * DIV + 1);

  generate
    if (DIV < 4) begin : g_bad_div
      $error("uart_rx_oversampled: CLOCKFRQ/BAUDRATE must be at least 4");
    end
  endgenerate

  // cnt_q is the number of cycles since the detection cycle t0 (t0 itself is
  // 0, so the first START cycle carries 1). The sample flops capture rxs in
  // the cycles with offset H-2..H inside a bit, so the three samples are
  // held at offsets H-1..H+1 and the vote is taken at offset H+1.
  localparam logic [CW-1:0] SMP_FIRST = CW'(H - 2);
  localparam logic [CW-1:0] SMP_LAST  = CW'(H);
  localparam logic [CW-1:0] DECIDE    = CW'(H + 1);
  localparam logic [CW-1:0] BIT_LEN   = CW'(DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   base_q, base_d;   // k*DIV for the bit currently being sampled
  logic [3:0]      bit_q, bit_d;
  logic [2:0]      smp_q, smp_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            received_q, received_d;
  logic            recv_error_q, recv_error_d;
  logic            armed_q, armed_d;

  logic            rxs;
  logic [CW-1:0]   off;
  logic            maj;

  assign rxs = sync_q[1];
  assign off = cnt_q - base_q;
  assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= 2'b11;
      state_q      <= IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      bit_q        <= 4'd0;
      smp_q        <= 3'b111;
      shift_q      <= 8'h00;
      rx_byte_q    <= 8'h00;
      received_q   <= 1'b0;
      recv_error_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], bus.rx};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      bit_q        <= bit_d;
      smp_q        <= smp_d;
      shift_q      <= shift_d;
      rx_byte_q    <= rx_byte_d;
      received_q   <= received_d;
      recv_error_q <= recv_error_d;
      armed_q      <= armed_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    base_d       = base_q;
    bit_d        = bit_q;
    smp_d        = smp_q;
    shift_d      = shift_q;
    rx_byte_d    = rx_byte_q;
    received_d   = 1'b0;
    recv_error_d = 1'b0;
    armed_d      = armed_q;

    if (state_q != IDLE && off >= SMP_FIRST && off <= SMP_LAST) begin
      smp_d = {smp_q[1:0], rxs};
    end

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        base_d = '0;
        bit_d  = 4'd0;
        if (rxs) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
          cnt_d   = CW'(1);
          armed_d = 1'b0;
        end
      end
      START: begin
        if (off == DECIDE) begin
          if (maj) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            base_d  = base_q + BIT_LEN;
            bit_d   = 4'd1;
          end
        end
      end
      DATA: begin
        if (off == DECIDE) begin
          shift_d = {maj, shift_q[7:1]};
          base_d  = base_q + BIT_LEN;
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd8) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (off == DECIDE) begin
          state_d = IDLE;
          if (maj) begin
            rx_byte_d  = shift_q;
            received_d = 1'b1;
            // The stop bit just voted high, so a start edge in the very next
            // cycle must be caught: stay armed.
            armed_d    = 1'b1;
          end else begin
            recv_error_d = 1'b1;
            // Line may be held low (break): wait for it to go high first.
            armed_d      = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_byte      = rx_byte_q;
  assign bus.received     = received_q;
  assign bus.recv_error   = recv_error_q;
  assign bus.is_receiving = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - randomized self-checking bench for uart_rx_oversampled
`timescale 1ns/1ps
module tb_uart_rx_oversampled;
  localparam int DIV = 12;
  localparam int H   = DIV / 2;
  // pin edge -> rxs (2) -> strobe at t0 + 9*DIV + H + 2
  localparam int LAT = 2 + 9 * DIV + H + 2;

  typedef struct {
    int         t;
    bit         err;
    logic [7:0] b;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_oversampled_if bus_if ();

  uart_rx_oversampled #(
    .CLOCKFRQ(12000000),
    .BAUDRATE(1000000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_tests = 0;
  int         n_fail  = 0;
  ev_t        exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         busy_cnt = 0;
  bit         prev_strobe = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      bus_if.rx = 1'b1;
    end
  endtask

  // Sends one frame with bit period per/100 cycles. glitch_at inverts the line
  // for one cycle at that offset; rst_at pulses reset for 3 cycles there.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int per,
                            input int glitch_at, input int rst_at);
    int         ncyc;
    int         p;
    logic [9:0] bits;
    logic       lvl;
    ev_t        e;
    ncyc = (10 * per + 99) / 100;
    bits = {stop, b, 1'b0};
    tick();
    p = cyc;
    if (rst_at < 0) begin
      e.t   = p + LAT;
      e.err = !stop;
      if (stop) last_good = b;
      e.b   = last_good;
      exp_q.push_back(e);
    end else begin
      last_good = 8'h00;
    end
    for (int i = 0; i < ncyc; i++) begin
      if (i > 0) tick();
      lvl = bits[(i * 100) / per];
      if (i == glitch_at) lvl = ~lvl;
      bus_if.rx = lvl;
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        check_eq("rst_rx_byte", bus_if.rx_byte, 8'h00);
        check_eq("rst_received", bus_if.received, 1'b0);
        check_eq("rst_recv_error", bus_if.recv_error, 1'b0);
        check_eq("rst_is_receiving", bus_if.is_receiving, 1'b0);
      end
      if (rst_at >= 0 && i == rst_at + 3) rst = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.is_receiving) busy_cnt++;
      if (bus_if.received || bus_if.recv_error) begin
        check_eq("strobe_exclusive", bus_if.received & bus_if.recv_error, 1'b0);
        check_eq("strobe_width", prev_strobe, 1'b0);
        if (exp_q.size() == 0) begin
          check_eq("spurious_strobe", 1, 0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check_eq("strobe_time", cyc, e.t);
          check_eq("strobe_kind_err", bus_if.recv_error, e.err);
          check_eq("rx_byte", bus_if.rx_byte, e.b);
        end
      end
      prev_strobe = bus_if.received | bus_if.recv_error;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected below 80000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    bus_if.rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_rx_byte", bus_if.rx_byte, 8'h00);
    check_eq("reset_received", bus_if.received, 1'b0);
    check_eq("reset_recv_error", bus_if.recv_error, 1'b0);
    check_eq("reset_is_receiving", bus_if.is_receiving, 1'b0);
    rst = 1'b0;
    idle(5);

    // Good byte
    busy_cnt = 0;
    send_frame(8'hA5, 1'b1, 1200, -1, -1);
    idle(10);
    check_eq("busy_len", busy_cnt, 115);
    check_eq("hold_a5", bus_if.rx_byte, 8'hA5);

    // Back-to-back
    send_frame(8'h00, 1'b1, 1200, -1, -1);
    send_frame(8'hFF, 1'b1, 1200, -1, -1);
    send_frame(8'h72, 1'b1, 1200, -1, -1);
    idle(10);

    // False start and in-bit glitch
    tick(); bus_if.rx = 1'b0;
    tick(); bus_if.rx = 1'b0;
    tick(); bus_if.rx = 1'b0;
    idle(20);
    check_eq("false_start_idle", bus_if.is_receiving, 1'b0);
    send_frame(8'h3C, 1'b1, 1200, 4 * DIV + H - 1, -1);
    idle(10);

    // Framing error followed by a break
    send_frame(8'h11, 1'b1, 1200, -1, -1);
    send_frame(8'h55, 1'b0, 1200, -1, -1);
    for (int i = 0; i < 5 * DIV; i++) begin
      tick();
      bus_if.rx = 1'b0;
    end
    check_eq("break_not_receiving", bus_if.is_receiving, 1'b0);
    check_eq("break_hold_11", bus_if.rx_byte, 8'h11);
    idle(20);
    send_frame(8'h99, 1'b1, 1200, -1, -1);
    idle(10);

    // Reset at data bit 4 of a frame, then a full frame
    send_frame(8'hF0, 1'b1, 1200, -1, 5 * DIV + H);
    idle(10);
    send_frame(8'h5A, 1'b1, 1200, -1, -1);
    idle(10);

    // Baud skew +3% and -3%
    for (int i = 0; i < 256; i++) begin
      rb = 8'($urandom);
      send_frame(rb, 1'b1, 1165, -1, -1);
      idle($urandom_range(2, 10));
    end
    for (int i = 0; i < 256; i++) begin
      rb = 8'($urandom);
      send_frame(rb, 1'b1, 1237, -1, -1);
      idle($urandom_range(2, 10));
    end

    idle(150);
    check_eq("pending_events", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

Standalone UART receiver: recovers 8N1 bytes from an asynchronous serial line, the receiving end of the 8N1 streams the designs emit, e.g. the random-byte stream at 1 Mbaud from a 12 MHz clock. It synchronises the line and re-centres on every start-bit edge. Each bit is decided by a 3-sample majority vote at the bit centre. Each byte is delivered as a single-cycle strobe, and framing errors are flagged. It drops into the same slot as the UART receive path next to the transmitter and feeds command decoders (for example the 'r' = 0x72 reset hook) or stream checkers.

## Interface
- CLOCKFRQ, 12000000, clock frequency in Hz
- BAUDRATE, 1000000, line rate in baud; DIV = CLOCKFRQ/BAUDRATE (integer division) must be ≥ 4, and the block fails elaboration otherwise
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- rx  input  1  serial line, idle high, asynchronous to clk
- rx_byte  output  8  last correctly framed byte, LSB first on the line
- received  output  1  one-cycle strobe: rx_byte was updated this cycle
- recv_error  output  1  one-cycle strobe: stop bit sampled low
- is_receiving  output  1  high while a frame is in progress (any state except IDLE)

## Operation
- **Synchroniser.** rx passes through 2 flops, both reset to 1. All logic uses the synchronised signal rxs.
- **Counter and sampling.**
  - cnt counts clk cycles from the detected start edge and is wide enough for 10*DIV.
  - H = DIV/2 (integer division).
  - Bit k (0 = start, 1..8 = data, 9 = stop) is sampled at cnt = k*DIV+H-1, k*DIV+H and k*DIV+H+1.
  - The decision is the majority of the 3 samples, taken in the cycle after the third sample.
- **States:** IDLE, START, DATA, STOP.
  - IDLE: armed only after rxs has been 1 for at least one cycle. When rxs reads 0 while armed, go to START with cnt = 0.
  - START: on the start-bit decision, a majority of 1 means a false start. Return to IDLE; raise no error and no strobe. A majority of 0 goes to DATA.
  - DATA: each decided bit is shifted in LSB first. After bit 8, go to STOP.
  - STOP: on the decision, a majority of 1 loads rx_byte from the shift register and pulses received. A majority of 0 pulses recv_error and leaves rx_byte unchanged. In both cases return to IDLE in the same cycle.
  - IDLE re-arms only once rxs = 1, so a held-low line (break) produces one recv_error and then nothing until the line goes high.
- **Early return.** Returning to IDLE at mid stop bit is required, so a start edge directly after the stop bit is caught.
- **Strobes.** received and recv_error are mutually exclusive and never high for more than 1 cycle.
- **Reset.** Reset at any time, including mid-frame, aborts the frame without any strobe.
  - State goes to IDLE and IDLE is disarmed until rxs = 1.
  - Reset values: rx_byte = 0x00, received = 0, recv_error = 0, is_receiving = 0, synchroniser = 1.

## Timing
- **Edge detection.** Let t0 be the first cycle where rxs = 0 in armed IDLE. is_receiving goes high at t0+1.
- **Pin to rxs.** A falling edge on pin rx is visible on rxs 2 cycles later.
- **Strobe latency.** The received or recv_error strobe is registered and appears at t0 + 9*DIV + H + 2.
  - For DIV = 12 this is t0+116, which is pin edge + 118 cycles.
  - is_receiving drops in the same cycle as the strobe.
- **Output hold.** rx_byte is valid from the received cycle onward and is held until the next good frame.
- **Throughput.** Back-to-back frames with zero idle between stop and the next start are received without loss.
- **Tolerance.** Required clock tolerance is at least ±3% baud mismatch at DIV = 12.
- **Glitch rejection.** A single-cycle glitch inside any bit is out-voted by the majority. A low pulse on rxs shorter than H-1 cycles is rejected as a false start.

## Test plan
- **Good byte.** Default parameters, send 0xA5 with stop = 1. Expect received for exactly 1 cycle at pin edge + 118, rx_byte = 0xA5, recv_error never high, is_receiving high for 115 cycles.
- **Back-to-back.** Send 0x00, 0xFF, 0x72 with no idle gap. Expect 3 received strobes spaced 120 cycles apart with rx_byte 0x00, 0xFF, 0x72, and no errors.
- **Glitches.** Drive a 3-cycle low pulse on an idle line; expect no strobe and is_receiving back to 0 after the false start. Then send 0x3C with a 1-cycle inverted glitch at the centre of bit 3; expect rx_byte = 0x3C.
- **Framing error and break.** Receive 0x11, then send 0x55 with stop = 0 and hold the line low for 5 bit times. Expect exactly one recv_error, no received, rx_byte still 0x11, and no further events until the line returns high. A subsequent 0x99 is received correctly.
- **Reset mid-frame.** Assert rst at data bit 4 of a frame. Outputs go to reset values asynchronously and no strobe occurs. After release, the remainder of the aborted frame produces no byte, and the next full 0x5A frame is received.
- **Baud skew.** Send 256 random bytes at baud +3% and −3%. Every byte matches and recv_error stays 0.
